// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flags, 2-entry in-order skid buffer
// toward writeback, and a saturating overflow event counter.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake
//   in_opcode/op1/op2      operands and opcode given to alu_simple
//   in_alu_out, in_rd      ALU result and destination register
//   out_valid/out_ready    writeback handshake for the head entry
//   out_result/rd/wen      head entry payload and write enable
//   out_zero/neg/ovf       head entry flags
//   ovf_count              overflowing entries retired (saturating)
//   out_trap               head entry overflowed (ALU_OVF_TRAP_EN only)
//
// Optional feature macro: ALU_OVF_TRAP_EN
module alu_result_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [3:0]  OP_ADD = 4'b0000,
    parameter logic [3:0]  OP_SUB = 4'b0001,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [WIDTH-1:0] in_alu_out,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count
`ifdef ALU_OVF_TRAP_EN
    ,
    output logic             out_trap
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [4:0]       rd;
        logic             wen;
        logic             zero;
        logic             neg;
        logic             ovf;
    } ent_t;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    ent_t             head_q, head_d;
    ent_t             tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ent_t             new_e;
    logic             push, pop, ovf;
    logic             a_s, b_s, r_s;

    // Only the sign bits of the operands matter for overflow.
    logic unused_ok;
    assign unused_ok = ^{in_op1[WIDTH-2:0], in_op2[WIDTH-2:0]};

    assign a_s = in_op1[WIDTH-1];
    assign b_s = in_op2[WIDTH-1];
    assign r_s = in_alu_out[WIDTH-1];

    always_comb begin
        ovf = 1'b0;
        unique case (1'b1)
            (in_opcode == OP_ADD): ovf = (a_s == b_s) && (r_s != a_s);
            (in_opcode == OP_SUB): ovf = (a_s != b_s) && (r_s != a_s);
            default:               ovf = 1'b0;
        endcase
    end

    always_comb begin
        new_e      = '0;
        new_e.res  = in_alu_out;
        new_e.rd   = in_rd;
        new_e.zero = (in_alu_out == '0);
        new_e.neg  = r_s;
        new_e.ovf  = ovf;
`ifdef ALU_OVF_TRAP_EN
        new_e.wen  = !ovf;
`else
        new_e.wen  = 1'b1;
`endif
    end

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head slot drives the outputs; tail only fills when head is busy.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = new_e;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    tail_d  = new_e;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop && head_q.ovf && !(&cnt_q))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_result = head_q.res;
    assign out_rd     = head_q.rd;
    assign out_wen    = head_q.wen;
    assign out_zero   = head_q.zero;
    assign out_neg    = head_q.neg;
    assign out_ovf    = head_q.ovf;
    assign ovf_count  = cnt_q;
`ifdef ALU_OVF_TRAP_EN
    assign out_trap   = head_q.ovf;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors queue
// expected entries, a negedge monitor retires and compares them.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_op1 = '0;
    logic [31:0] in_op2 = '0;
    logic [31:0] in_alu_out = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen, out_zero, out_neg, out_ovf;
    logic [15:0] ovf_count;
`ifdef ALU_OVF_TRAP_EN
    logic        out_trap;
`endif

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
        .in_alu_out(in_alu_out), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .ovf_count(ovf_count)
`ifdef ALU_OVF_TRAP_EN
        , .out_trap(out_trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen, zero, neg, ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mcnt = '0;
    int          total = 0;
    int          bad = 0;
    int          last_wait = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Scoreboard monitor: retire on each observed pop.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ovf_count", {16'd0, ovf_count}, {16'd0, mcnt});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", out_result, e.res);
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("wen", {31'd0, out_wen}, {31'd0, e.wen});
                    chk("zero", {31'd0, out_zero}, {31'd0, e.zero});
                    chk("neg", {31'd0, out_neg}, {31'd0, e.neg});
                    chk("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
`ifdef ALU_OVF_TRAP_EN
                    chk("trap", {31'd0, out_trap}, {31'd0, e.ovf});
`endif
                    if (e.ovf && mcnt != 16'hFFFF) mcnt++;
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input logic [4:0] rd, input bit ovf,
                        input bit zero, input bit neg);
        exp_t e;
        int   n;
        bit   acc;
        e.res  = r;
        e.rd   = rd;
        e.ovf  = ovf;
        e.zero = zero;
        e.neg  = neg;
`ifdef ALU_OVF_TRAP_EN
        e.wen  = !ovf;
`else
        e.wen  = 1'b1;
`endif
        exp_q.push_back(e);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_op1     = a;
        in_op2     = b;
        in_alu_out = r;
        in_rd      = rd;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("push_timeout", 32'd1, 32'd0);
        last_wait = n;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int cyc;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_wen", {31'd0, out_wen}, 32'd0);
        chk("rst_cnt", {16'd0, ovf_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add overflow, latency of one edge
        out_ready = 1'b1;
        send(4'b0000, 32'h80000001, 32'h80000001, 32'h00000002, 5'd1,
             1, 0, 0);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_result", out_result, 32'h2);
        chk("lat_ovf", {31'd0, out_ovf}, 32'd1);
`ifdef ALU_OVF_TRAP_EN
        chk("lat_trap", {31'd0, out_trap}, 32'd1);
        chk("lat_wen", {31'd0, out_wen}, 32'd0);
`endif
        drain();
        chk("cnt_after_add", {16'd0, ovf_count}, 32'd1);

        // sub overflow then sub to zero
        send(4'b0001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 5'd2,
             1, 0, 1);
        send(4'b0001, 32'd5, 32'd5, 32'd0, 5'd3, 0, 1, 0);
        // other boundary patterns
        send(4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'd4, 1, 0, 1);
        send(4'b0000, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd5, 0, 1, 0);
        send(4'b0010, 32'h80000000, 32'h80000000, 32'h0, 5'd6, 0, 1, 0);
        send(4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 5'd7, 1, 0, 0);
        drain();
        chk("cnt_after_sub", {16'd0, ovf_count}, 32'd4);

        // backpressure: two fill, third held
        out_ready = 1'b0;
        send(4'b0011, 32'h0, 32'h0, 32'h11, 5'd1, 0, 0, 0);
        send(4'b0011, 32'h0, 32'h0, 32'h22, 5'd2, 0, 0, 0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(4'b0011, 32'h0, 32'h0, 32'h33, 5'd3, 0, 0, 0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("held_rd", {27'd0, out_rd}, 32'd1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // full-rate push/pop in ONE
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            send(4'b0000, i, i, 2 * i, 5'(10 + i), 0, (i == 0), 0);
            cyc += last_wait;
        end
        chk("fullrate_cycles", cyc, 32'd10);
        chk("fullrate_in_ready", {31'd0, in_ready}, 32'd1);
        drain();

        // counter saturation
        force dut.cnt_q = 16'hFFFE;
        mcnt = 16'hFFFE;
        #1;
        release dut.cnt_q;
        for (int i = 0; i < 3; i++)
            send(4'b0000, 32'h80000000, 32'h80000000, 32'h0, 5'(20 + i),
                 1, 1, 0);
        drain();
        chk("cnt_sat", {16'd0, ovf_count}, 32'h0000FFFF);

        // reset in TWO, between edges
        out_ready = 1'b0;
        send(4'b0011, 32'h0, 32'h0, 32'hAA, 5'd8, 0, 0, 0);
        send(4'b0011, 32'h0, 32'h0, 32'hBB, 5'd9, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_cnt", {16'd0, ovf_count}, 32'd0);
        exp_q.delete();
        mcnt = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        send(4'b0011, 32'h0, 32'h0, 32'h1234, 5'd17, 0, 0, 0);
        chk("post_rst_rd", {27'd0, out_rd}, 32'd17);
        drain();
        chk("post_rst_cnt", {16'd0, ovf_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered result stage directly downstream of alu_simple in the execute path. Captures the ALU operands, opcode and combinational result plus destination register index, and derives zero, negative and signed-overflow flags for add/sub. Holds results in a 2-entry in-order skid buffer with valid/ready handshakes toward writeback, and keeps a saturating overflow event counter.

Parameters:
WIDTH, 32, datapath width of operands and result
OP_ADD, 4'b0000, opcode value treated as signed addition
OP_SUB, 4'b0001, opcode value treated as signed subtraction
CNT_W, 16, width of overflow event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_opcode  in  4  opcode presented to alu_simple
in_op1  in  WIDTH  In1 presented to alu_simple
in_op2  in  WIDTH  In2 presented to alu_simple
in_alu_out  in  WIDTH  Out from alu_simple
in_rd  in  5  destination register index
out_valid  out  1  head entry valid
out_ready  in  1  writeback accepts head entry
out_result  out  WIDTH  registered ALU result
out_rd  out  5  destination register index
out_wen  out  1  register write enable for head entry
out_zero  out  1  result == 0
out_neg  out  1  result[WIDTH-1]
out_ovf  out  1  signed overflow of add/sub
ovf_count  out  CNT_W  count of overflowing entries retired

Behaviour:
- Clock/reset: one clock; reset is asynchronous, active-low (rst_n). On assertion: state EMPTY, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_wen=0, out_zero=0, out_neg=0, out_ovf=0, ovf_count=0. Reset mid-operation discards all buffered entries; no partial retire.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Flags computed at push from captured inputs: zero = (in_alu_out==0); neg = in_alu_out[WIDTH-1].
- Overflow: OP_ADD: op1[MSB]==op2[MSB] and out[MSB]!=op1[MSB]. OP_SUB: op1[MSB]!=op2[MSB] and out[MSB]!=op1[MSB]. All other opcodes: ovf=0.
- out_wen = 1 for every pushed entry (see Optional Feature).
- FSM on occupancy: EMPTY, ONE, TWO. EMPTY: push->ONE. ONE: push&!pop->TWO; pop&!push->EMPTY; push&pop->ONE (new entry becomes head next cycle). TWO: pop->ONE; push impossible.
- in_ready = (state != TWO), purely from registered state; out_valid = (state != EMPTY).
- Latency: entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when buffer was empty or head popped same cycle. Strict FIFO order.
- out_* stable while out_valid=1 and out_ready=0.
- out_valid=0: out_* hold last values; not meaningful.
- ovf_count increments by 1 on each pop whose entry has ovf=1; saturates at all-ones, no wrap.
- in_* ignored when in_ready=0.

Optional Feature:
ALU_OVF_TRAP_EN: when defined, adds output out_trap (1 bit, reset 0) = out_ovf of head entry, and any entry with ovf=1 has out_wen forced 0 (result not written back; still retired and counted). When undefined, out_trap port is absent and out_wen is always 1 for valid entries.

Test Plan:
- Add overflow: opcode=0000, op1=op2=0x80000001, alu_out=0x00000002, out_ready=1 -> next cycle out_valid=1, out_result=0x00000002, out_ovf=1, out_zero=0, out_neg=0, ovf_count=1 after pop; with ALU_OVF_TRAP_EN out_wen=0, out_trap=1.
- Sub overflow/no-overflow: opcode=0001, op1=0x7FFFFFFF, op2=0xFFFFFFFF, alu_out=0x80000000 -> out_ovf=1, out_neg=1; then op1=5, op2=5, alu_out=0 -> out_ovf=0, out_zero=1, out_wen=1.
- Backpressure: out_ready=0, push 3 back-to-back entries (rd=1,2,3) -> in_ready falls after 2nd push, 3rd held; release out_ready -> rd 1,2,3 retire in order, no loss or duplication.
- Simultaneous push/pop in ONE at full rate for 10 cycles -> in_ready stays 1, one result per cycle, order preserved.
- Counter saturation: preload by forcing ovf_count=0xFFFE, retire 3 overflowing adds -> ovf_count 0xFFFF, stays 0xFFFF.
- Reset mid-operation: buffer in TWO, assert rst_n=0 asynchronously between edges -> immediately out_valid=0, in_ready=1, ovf_count=0; after release, first new push appears with no stale entry.
